// File: rtl/jk_cmd_sequencer.sv
// FIFO-buffered JK command sequencer: issues one J/K/enable pulse per command, then a CHECK cycle.
// Optional macro JK_CHECK_EN adds a Q reference model with a sticky mismatch flag (err).
module jk_cmd_sequencer #(
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_valid,
  input  logic [1:0]    i_cmd,
  output logic          o_cmd_ready,
  input  logic          i_run,
  input  logic          i_q,
  output logic          o_j,
  output logic          o_k,
  output logic          o_ff_en,
  output logic          o_busy,
  output logic [AW:0]   o_count,
  output logic          o_err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_j;
  logic          r_k;
  logic          r_ff_en;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head;

  assign o_cmd_ready = (r_count < FULL);
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_head      = r_mem[r_rptr];

  // A new command may only be popped outside ISSUE, so pops are at least two cycles apart.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE, S_CHECK: begin
        w_pop  = i_run && (r_count != '0);
        w_next = w_pop ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: w_next = S_CHECK;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_ff_en <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ff_en <= w_pop;
      r_j     <= w_pop & w_head[1];
      r_k     <= w_pop & w_head[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_cmd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_j     = r_j;
  assign o_k     = r_k;
  assign o_ff_en = r_ff_en;
  assign o_busy  = (r_state != S_IDLE);
  assign o_count = r_count;

`ifdef JK_CHECK_EN
  logic r_exp;
  logic r_err;

  // r_exp tracks what Q should become once the flip-flop samples the command being issued.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exp <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_pop) begin
        case (w_head)
          2'b01:   r_exp <= 1'b0;
          2'b10:   r_exp <= 1'b1;
          2'b11:   r_exp <= ~r_exp;
          default: r_exp <= r_exp;
        endcase
      end
      if ((r_state == S_CHECK) && (i_q != r_exp)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_q;

  assign w_unused_q = i_q;
  assign o_err      = 1'b0;
`endif

endmodule
